// File: rtl/ct_f_spsram_init_wrap_pkg.sv
// Shared definitions for the self-initialising single-port SRAM wrapper.
// Holds the FSM state encoding and the LANES/DEPTH derivation helpers.
package ct_f_spsram_init_wrap_pkg;

  // Init walk vs. normal user access.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  // Number of entries for a given address width.
  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // Number of write-enable lanes for a given data width and lane granularity.
  function automatic int unsigned lanes_of(input int unsigned data_width,
                                           input int unsigned wen_gran);
    return data_width / wen_gran;
  endfunction

endpackage

// File: rtl/ct_f_spsram_lane.sv
// One write-enable lane of the SRAM: WIDTH bits wide, 2^ADDR_WIDTH deep,
// synchronous write and synchronous read on the same port.
// Ports:
//   clk   - clock
//   addr  - entry address
//   we    - write enable (active-high)
//   re    - read enable (active-high); rdata updates on the edge it is sampled
//   wdata - write data
//   rdata - registered read data
module ct_f_spsram_lane #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned WIDTH      = 1
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic                  re,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);
  import ct_f_spsram_init_wrap_pkg::*;

  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);

  logic [WIDTH-1:0] mem [DEPTH];

  // Array storage is never reset; the init walk clears it instead.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ct_f_spsram_init_wrap.sv
// Single-port SRAM wrapper with per-lane write mask and automatic
// initialisation. After reset, or on init_req, every entry is written with
// INIT_VAL while init_busy is high; user accesses are ignored meanwhile.
// Read data is held on Q until the next read returns.
// Ports:
//   forever_cpuclk - clock
//   cpurst_b       - asynchronous active-low reset
//   A              - access address
//   CEN            - chip enable, active-low
//   GWEN           - global write enable, active-low (1 = read)
//   WEN            - per-lane write enable, active-low
//   D              - write data
//   init_req       - pulse, restarts initialisation from entry 0
//   Q              - read data (held between reads)
//   rd_vld         - one-cycle pulse when Q takes new read data
//   init_busy      - initialisation in progress
module ct_f_spsram_init_wrap
  import ct_f_spsram_init_wrap_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 11,
  parameter int unsigned           DATA_WIDTH = 88,
  parameter int unsigned           WEN_GRAN   = 1,
  parameter int unsigned           OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                                      forever_cpuclk,
  input  logic                                      cpurst_b,
  input  logic [ADDR_WIDTH-1:0]                     A,
  input  logic                                      CEN,
  input  logic                                      GWEN,
  input  logic [lanes_of(DATA_WIDTH, WEN_GRAN)-1:0] WEN,
  input  logic [DATA_WIDTH-1:0]                     D,
  input  logic                                      init_req,
  output logic [DATA_WIDTH-1:0]                     Q,
  output logic                                      rd_vld,
  output logic                                      init_busy
);

  localparam int unsigned LANES = lanes_of(DATA_WIDTH, WEN_GRAN);
  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
  logic                    init_busy_d;

  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [LANES-1:0]        ram_we;
  logic                    ram_re;
  logic [DATA_WIDTH-1:0]   ram_wdata;
  logic [DATA_WIDTH-1:0]   ram_rdata;

  logic                    rd_pend_q;
  logic                    hold_vld_q;
  logic [DATA_WIDTH-1:0]   q_hold_q;

  // FSM state, init counter and busy flag.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      init_busy  <= 1'b1;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      init_busy  <= init_busy_d;
    end
  end

  // Next state plus the init/user mux onto the array port.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ram_addr   = A;
    ram_we     = '0;
    ram_re     = 1'b0;
    ram_wdata  = D;
    case (state_q)
      ST_INIT: begin
        ram_addr  = init_cnt_q;
        ram_we    = '1;
        ram_wdata = INIT_VAL;
        if (init_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d    = ST_IDLE;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_IDLE: begin
        // The access presented alongside init_req still goes through.
        ram_re = ~CEN & GWEN;
        ram_we = (~CEN & ~GWEN) ? ~WEN : '0;
        if (init_req) begin
          state_d    = ST_INIT;
          init_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_INIT;
        init_cnt_d = '0;
      end
    endcase
    init_busy_d = (state_d == ST_INIT);
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    ct_f_spsram_lane #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .WIDTH     (WEN_GRAN)
    ) u_lane (
      .clk  (forever_cpuclk),
      .addr (ram_addr),
      .we   (ram_we[j]),
      .re   (ram_re),
      .wdata(ram_wdata[j*WEN_GRAN +: WEN_GRAN]),
      .rdata(ram_rdata[j*WEN_GRAN +: WEN_GRAN])
    );
  end

  // Holding register: captures array output one cycle after the read.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_pend_q  <= 1'b0;
      hold_vld_q <= 1'b0;
      q_hold_q   <= '0;
    end else begin
      rd_pend_q  <= ram_re;
      hold_vld_q <= rd_pend_q;
      if (rd_pend_q) begin
        q_hold_q <= ram_rdata;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] q_out_q;
    logic                  out_vld_q;

    // Extra output stage, adds one cycle of read latency.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
        q_out_q   <= '0;
        out_vld_q <= 1'b0;
      end else begin
        out_vld_q <= hold_vld_q;
        if (hold_vld_q) begin
          q_out_q <= q_hold_q;
        end
      end
    end

    assign Q      = q_out_q;
    assign rd_vld = out_vld_q;
  end else begin : g_no_out_reg
    assign Q      = q_hold_q;
    assign rd_vld = hold_vld_q;
  end

endmodule

// File: tb/tb_ct_f_spsram_init_wrap.sv
// Bench for ct_f_spsram_init_wrap: two instances (OUT_REG=0 and OUT_REG=1)
// share stimulus and are compared each cycle against a behavioural model.
module tb_ct_f_spsram_init_wrap;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned GR    = 4;
  localparam int unsigned LN    = 2;
  localparam int unsigned DEPTH = 16;
  localparam logic [7:0]  IV    = 8'hA5;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] a;
  logic          cen;
  logic          gwen;
  logic [LN-1:0] wen;
  logic [DW-1:0] d;
  logic          init_req;
  logic [DW-1:0] q0, q1;
  logic          v0, v1, b0, b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ct_f_spsram_init_wrap #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WEN_GRAN(GR), .OUT_REG(0), .INIT_VAL(IV)
  ) dut0 (
    .forever_cpuclk(clk), .cpurst_b(rst_n), .A(a), .CEN(cen), .GWEN(gwen),
    .WEN(wen), .D(d), .init_req(init_req), .Q(q0), .rd_vld(v0), .init_busy(b0)
  );

  ct_f_spsram_init_wrap #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WEN_GRAN(GR), .OUT_REG(1), .INIT_VAL(IV)
  ) dut1 (
    .forever_cpuclk(clk), .cpurst_b(rst_n), .A(a), .CEN(cen), .GWEN(gwen),
    .WEN(wen), .D(d), .init_req(init_req), .Q(q1), .rd_vld(v1), .init_busy(b1)
  );

  int n_cmp;
  int n_bad;

  // Reference model: array contents, remaining init cycles, and reads in flight.
  typedef struct {
    int         due;
    logic [7:0] v;
  } rd_t;

  logic [7:0] mmem [DEPTH];
  int         m_left;
  int         cyc;
  rd_t        pend0[$];
  rd_t        pend1[$];
  logic [7:0] e_q0, e_q1;
  logic       e_v0, e_v1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_left = DEPTH;
    pend0.delete();
    pend1.delete();
    e_q0 = 8'h00;
    e_q1 = 8'h00;
    e_v0 = 1'b0;
    e_v1 = 1'b0;
  endtask

  task automatic model_edge();
    rd_t r;
    cyc++;
    e_v0 = 1'b0;
    e_v1 = 1'b0;
    if (pend0.size() > 0 && pend0[0].due == cyc) begin
      e_q0 = pend0[0].v;
      e_v0 = 1'b1;
      void'(pend0.pop_front());
    end
    if (pend1.size() > 0 && pend1[0].due == cyc) begin
      e_q1 = pend1[0].v;
      e_v1 = 1'b1;
      void'(pend1.pop_front());
    end
    if (m_left > 0) begin
      mmem[DEPTH - m_left] = IV;
      m_left--;
    end else begin
      if (!cen && gwen) begin
        r.v   = mmem[a];
        r.due = cyc + 1;
        pend0.push_back(r);
        r.due = cyc + 2;
        pend1.push_back(r);
      end else if (!cen && !gwen) begin
        for (int j = 0; j < LN; j++)
          if (!wen[j]) mmem[a][j*GR +: GR] = d[j*GR +: GR];
      end
      if (init_req) m_left = DEPTH;
    end
  endtask

  task automatic check_all();
    chk("q0",    32'(q0), 32'(e_q0));
    chk("vld0",  32'(v0), 32'(e_v0));
    chk("q1",    32'(q1), 32'(e_q1));
    chk("vld1",  32'(v1), 32'(e_v1));
    chk("busy0", 32'(b0), 32'(m_left > 0));
    chk("busy1", 32'(b1), 32'(m_left > 0));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_idle();
    cen      = 1'b1;
    gwen     = 1'b1;
    wen      = '1;
    d        = '0;
    a        = '0;
    init_req = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] aa, input logic [7:0] dd, input logic [1:0] ww);
    cen  = 1'b0;
    gwen = 1'b0;
    a    = aa;
    d    = dd;
    wen  = ww;
    cycle();
    set_idle();
  endtask

  task automatic do_read(input logic [3:0] aa);
    cen  = 1'b0;
    gwen = 1'b1;
    a    = aa;
    cycle();
    set_idle();
  endtask

  task automatic count_busy(input string nm);
    int n;
    n = 0;
    while (b0 && n < 100) begin
      cycle();
      n++;
    end
    chk(nm, 32'(n), 32'(DEPTH));
  endtask

  typedef struct {
    bit         is_rd;
    logic [3:0] a;
    logic [1:0] wen;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  function automatic vec_t mk(input bit r, input logic [3:0] aa, input logic [1:0] ww,
                              input logic [7:0] dd, input logic [7:0] ee);
    vec_t v;
    v.is_rd = r;
    v.a     = aa;
    v.wen   = ww;
    v.d     = dd;
    v.exp   = ee;
    return v;
  endfunction

  vec_t       vt [9];
  logic [7:0] seq_vals [3];

  initial begin
    int pulses;
    int n;

    vt[0] = mk(1'b0, 4'd3, 2'b10, 8'h3C, 8'h00);
    vt[1] = mk(1'b1, 4'd3, 2'b11, 8'h00, 8'hAC);
    vt[2] = mk(1'b0, 4'd3, 2'b00, 8'h77, 8'h00);
    vt[3] = mk(1'b1, 4'd3, 2'b11, 8'h00, 8'h77);
    vt[4] = mk(1'b0, 4'd3, 2'b11, 8'h00, 8'h00);
    vt[5] = mk(1'b1, 4'd3, 2'b11, 8'h00, 8'h77);
    vt[6] = mk(1'b0, 4'd9, 2'b01, 8'hF0, 8'h00);
    vt[7] = mk(1'b1, 4'd9, 2'b11, 8'h00, 8'hF5);
    vt[8] = mk(1'b1, 4'd0, 2'b11, 8'h00, 8'hA5);
    seq_vals[0] = 8'h12;
    seq_vals[1] = 8'h34;
    seq_vals[2] = 8'h56;

    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    for (int i = 0; i < DEPTH; i++) mmem[i] = 8'h00;
    set_idle();
    model_reset();

    // Reset values, then init length after release.
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    check_all();
    chk("rst_busy", 32'(b0), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    count_busy("init_len_after_reset");

    // Every entry reads back as the init value.
    for (int i = 0; i < DEPTH; i++) begin
      cen  = 1'b0;
      gwen = 1'b1;
      a    = 4'(i);
      cycle();
      if (i > 0) chk("init_rd_vld", 32'(v0), 32'd1);
    end
    set_idle();
    cycle();
    cycle();

    // Directed write-mask table.
    for (int i = 0; i < 9; i++) begin
      if (vt[i].is_rd) begin
        do_read(vt[i].a);
        cycle();
        cycle();
        chk("tbl_q0", 32'(q0), 32'(vt[i].exp));
        chk("tbl_q1", 32'(q1), 32'(vt[i].exp));
      end else begin
        do_write(vt[i].a, vt[i].d, vt[i].wen);
      end
    end

    // Q holds through idle cycles and a write; one rd_vld pulse.
    do_read(4'd3);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      pulses += int'(v0);
    end
    do_write(4'd4, 8'h11, 2'b00);
    pulses += int'(v0);
    cycle();
    pulses += int'(v0);
    chk("hold_q", 32'(q0), 32'h77);
    chk("hold_pulses", 32'(pulses), 32'd1);

    // Back-to-back reads through the output-register instance.
    do_write(4'd1, 8'h12, 2'b00);
    do_write(4'd2, 8'h34, 2'b00);
    do_write(4'd3, 8'h56, 2'b00);
    for (int k = 1; k <= 6; k++) begin
      if (k <= 3) begin
        cen  = 1'b0;
        gwen = 1'b1;
        a    = 4'(k);
      end else begin
        set_idle();
      end
      cycle();
      chk("b2b_vld1", 32'(v1), 32'(k >= 3 && k <= 5));
      if (k >= 3 && k <= 5) chk("b2b_q1", 32'(q1), 32'(seq_vals[k-3]));
    end
    set_idle();

    // init_req with a read in the same cycle; writes during init are ignored.
    do_write(4'd5, 8'h5A, 2'b00);
    cen      = 1'b0;
    gwen     = 1'b1;
    a        = 4'd5;
    init_req = 1'b1;
    cycle();
    set_idle();
    chk("initreq_busy", 32'(b0), 32'd1);
    n = 0;
    while (b0 && n < 100) begin
      cen      = 1'($urandom_range(0, 1));
      gwen     = 1'($urandom_range(0, 1));
      a        = (n % 2 == 0) ? 4'd5 : 4'($urandom_range(0, 15));
      wen      = 2'($urandom_range(0, 3));
      d        = 8'($urandom_range(0, 255));
      init_req = (n == 5);
      cycle();
      n++;
      if (n == 1) begin
        chk("initreq_rd_vld", 32'(v0), 32'd1);
        chk("initreq_rd_q", 32'(q0), 32'h5A);
      end
    end
    set_idle();
    chk("init_len_after_req", 32'(n), 32'(DEPTH));
    do_read(4'd5);
    cycle();
    cycle();
    chk("post_init_q0", 32'(q0), 32'hA5);
    chk("post_init_q1", 32'(q1), 32'hA5);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cen      = ($urandom_range(0, 3) == 0);
      gwen     = 1'($urandom_range(0, 1));
      a        = 4'($urandom_range(0, 15));
      wen      = 2'($urandom_range(0, 3));
      d        = 8'($urandom_range(0, 255));
      init_req = ($urandom_range(0, 99) < 2);
      cycle();
    end
    set_idle();
    for (int i = 0; i < 20; i++) cycle();

    // Reset during init cycle 7.
    do_read(4'd2);
    cycle();
    cycle();
    init_req = 1'b1;
    cycle();
    set_idle();
    for (int i = 0; i < 7; i++) cycle();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("midinit_rst_q0", 32'(q0), 32'd0);
    chk("midinit_rst_v0", 32'(v0), 32'd0);
    chk("midinit_rst_busy", 32'(b0), 32'd1);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    count_busy("init_len_after_midinit_rst");

    // Reset with a read in flight: the read is dropped.
    do_write(4'd6, 8'h66, 2'b00);
    do_read(4'd6);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    count_busy("init_len_after_midread_rst");
    do_read(4'd6);
    cycle();
    cycle();
    chk("after_rst_q0", 32'(q0), 32'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/ct_f_spsram_init_wrap.md
# ct_f_spsram_init_wrap

Parametrised FPGA single-port SRAM wrapper for core-side arrays (caches, tag and history tables). Width, depth, write-mask granularity and read latency are all configurable. After reset, or on request, an internal state machine walks every entry and writes a fixed init value, so the arrays never need a software clear. Read data is held stable until the next read completes.

## Interface
Parameters:
- ADDR_WIDTH, 11, address bits; DEPTH = 2^ADDR_WIDTH
- DATA_WIDTH, 88, data bits
- WEN_GRAN, 1, bits per write-enable lane; DATA_WIDTH % WEN_GRAN == 0; LANES = DATA_WIDTH/WEN_GRAN
- OUT_REG, 0, 1 adds a registered output stage (read latency 2)
- INIT_VAL, 0, DATA_WIDTH-bit value written to every entry during init

Ports:
- forever_cpuclk  in  1  clock
- cpurst_b  in  1  reset, asynchronous, active-low
- A  in  ADDR_WIDTH  access address
- CEN  in  1  chip enable, active-low
- GWEN  in  1  global write enable, active-low (1 = read)
- WEN  in  LANES  per-lane write enable, active-low
- D  in  DATA_WIDTH  write data
- init_req  in  1  pulse; starts re-initialisation
- Q  out  DATA_WIDTH  read data, held between reads
- rd_vld  out  1  one-cycle pulse when Q takes new read data
- init_busy  out  1  init in progress; accesses are ignored

## Operation
- FSM states: INIT and IDLE. Reset state is INIT with the init counter at 0.
- INIT
  - Each cycle, write INIT_VAL to entry init_cnt on all lanes, then increment init_cnt.
  - When init_cnt == DEPTH-1 is written, go to IDLE and clear init_cnt.
  - CEN, GWEN, WEN, D and A are ignored; no read occurs and Q holds.
- IDLE
  - init_req=1 moves to INIT with init_cnt=0 on the next cycle. The access presented in the same cycle as init_req is still performed.
  - Read: CEN=0 and GWEN=1 returns mem[A].
  - Write: CEN=0 and GWEN=0 writes lane j (bits j*WEN_GRAN +: WEN_GRAN) with D when WEN[j]=0. Lanes with WEN[j]=1 keep their contents. A write never changes Q.
  - All WEN=1 with GWEN=0 is a no-op.
  - CEN=1 means no access; Q and the array hold.
- Read-during-init_req: the read completes normally and rd_vld pulses per its latency even though init_busy is already high.
- init_req while already in INIT: ignored; no restart.
- Reset asserted mid-init or mid-read: all state returns to its reset values immediately, the in-flight read is dropped (no rd_vld), and init restarts from entry 0. Array contents are not reset and are overwritten by init.
- Reset values: Q = 0, rd_vld = 0, init_busy = 1. The OUT_REG stage and its valid flag also reset to 0.

## Timing
- First init write happens on the first rising edge after cpurst_b deasserts.
- init_busy is high for exactly DEPTH cycles after reset release, and for DEPTH cycles starting the cycle after an accepted init_req.
- Read latency:
  - OUT_REG=0: read issued at edge N gives Q updated and rd_vld=1 after edge N+1.
  - OUT_REG=1: Q updated and rd_vld=1 after edge N+2.
- Back-to-back reads are fully pipelined: one read per cycle, in order.
- Write at edge N followed by a read of the same address at edge N+1 returns the new data. A read and a write never share a cycle (single port).

## Structure
- Shared header holds the FSM state encodings (INIT=1'b0, IDLE=1'b1) and the LANES/DEPTH derivation macros.
- One natural sub-module, ct_f_spsram_lane: a WEN_GRAN-bit wide, DEPTH-deep synchronous-read lane with a single write enable. It is instanced LANES times in a generate loop.
- Top level contains the FSM, init counter, address/data/enable muxing between init and user paths, and the read-data holding register plus the optional OUT_REG stage.

## Test plan
Bench config: ADDR_WIDTH=4, DATA_WIDTH=8, WEN_GRAN=4, INIT_VAL=8'hA5, unless stated otherwise.
- Reset release -> init_busy stays high for exactly 16 cycles, then falls. Reading addresses 0..15 returns 8'hA5, and rd_vld pulses one cycle after each read.
- Write A=3, D=8'h3C, WEN=2'b10 -> a later read of A=3 returns 8'hAC. Then write WEN=2'b00, D=8'h77 -> the read returns 8'h77. GWEN=0 with WEN=2'b11 -> the contents stay 8'h77.
- Read A=3 returning 8'h77, then 5 idle cycles, then a write of 8'h11 to A=4 -> Q stays 8'h77 throughout, and rd_vld pulses only once.
- OUT_REG=1, back-to-back reads of A=1,2,3 holding distinct data -> Q shows the three values in order, each 2 cycles after issue, with rd_vld high for 3 consecutive cycles.
- init_req while A=5 holds 8'h5A -> init_busy rises for 16 cycles, user writes during that window are ignored, and a read of A=5 afterwards returns 8'hA5.
- cpurst_b asserted at init cycle 7 -> Q=0, rd_vld=0, init_busy=1 immediately. After release, init takes a full 16 cycles again.
